// File: rtl/split_bus_arbiter.sv
// split_bus_arbiter: two-master/three-slave bus arbiter with round-robin grant, slave decode and timeout.
// Define ARB_SPLIT_EN to enable SPLIT responses and the per-master split mask.
module split_bus_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busreq_1,
  input  logic              busreq_2,
  input  logic              addr_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rdy,
  input  logic [1:0]        resp,
  input  logic              split_release_1,
  input  logic              split_release_2,
  output logic              grant_1,
  output logic              grant_2,
  output logic [1:0]        slave_sel,
  output logic              xfer_done,
  output logic              error,
  output logic [1:0]        split_mask
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  logic [1:0] state;
  logic       prio;
  logic [3:0] cnt;
  logic [1:0] elig;
  logic [1:0] dec;
  logic       pick2;
  logic       own_req;
  logic       tmo;
  logic       split_hit;
  logic       upd;
  assign elig    = {busreq_2 & ~split_mask[1], busreq_1 & ~split_mask[0]};
  assign pick2   = elig[1] & (~elig[0] | prio);
  assign own_req = grant_1 ? busreq_1 : busreq_2;
  assign dec     = addr[ADDR_W-1:ADDR_W-2];
  assign tmo     = ~rdy && cnt == 4'(TIMEOUT);
  assign upd     = tmo | ~resp[1] | split_hit;
`ifdef ARB_SPLIT_EN
  logic unused;
  assign unused    = ^addr[ADDR_W-3:0];
  assign split_hit = state == DATA && rdy && resp == 2'b10;
  // a SPLIT landing in the same cycle as a release for that master keeps it masked
  always_ff @(posedge clk or posedge rst)
    if (rst) split_mask <= 2'b00;
    else begin
      split_mask[0] <= (split_hit & grant_1) | (split_mask[0] & ~split_release_1);
      split_mask[1] <= (split_hit & grant_2) | (split_mask[1] & ~split_release_2);
    end
`else
  logic unused;
  assign unused     = ^{addr[ADDR_W-3:0], split_release_1, split_release_2};
  assign split_hit  = 1'b0;
  assign split_mask = 2'b00;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      grant_1   <= 1'b0;
      grant_2   <= 1'b0;
      slave_sel <= 2'd0;
      xfer_done <= 1'b0;
      error     <= 1'b0;
      prio      <= 1'b0;
      cnt       <= 4'd0;
    end else begin
      xfer_done <= 1'b0;
      error     <= 1'b0;
      case (state)
        IDLE:
          if (|elig) begin
            grant_1 <= ~pick2;
            grant_2 <= pick2;
            state   <= GRANT;
          end
        GRANT:
          if (!own_req || (addr_valid && dec == 2'b11)) begin
            grant_1 <= 1'b0;
            grant_2 <= 1'b0;
            error   <= own_req;
            state   <= IDLE;
          end else if (addr_valid) begin
            slave_sel <= dec;
            cnt       <= 4'd0;
            state     <= DATA;
          end
        DATA:
          if (rdy || tmo) begin
            grant_1   <= 1'b0;
            grant_2   <= 1'b0;
            xfer_done <= rdy && resp == 2'b00;
            error     <= tmo || (rdy && resp == 2'b01);
            state     <= IDLE;
            if (upd) prio <= grant_1;
          end else cnt <= cnt + 4'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_split_bus_arbiter.sv
// tb_split_bus_arbiter: scripted scoreboard bench; expected output vectors are queued per cycle and compared after each edge.
module tb_split_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        busreq_1, busreq_2, addr_valid, rdy;
  logic [15:0] addr;
  logic [1:0]  resp;
  logic        split_release_1, split_release_2;
  logic        grant_1, grant_2, xfer_done, error;
  logic [1:0]  slave_sel, split_mask;
  typedef struct {string tag; logic [7:0] exp;} exp_t;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  es;
  logic [1:0]  em;
  always #5 clk = ~clk;
  split_bus_arbiter dut (
    .clk(clk), .rst(rst), .busreq_1(busreq_1), .busreq_2(busreq_2),
    .addr_valid(addr_valid), .addr(addr), .rdy(rdy), .resp(resp),
    .split_release_1(split_release_1), .split_release_2(split_release_2),
    .grant_1(grant_1), .grant_2(grant_2), .slave_sel(slave_sel),
    .xfer_done(xfer_done), .error(error), .split_mask(split_mask)
  );
  function automatic logic [7:0] e(input logic g1, input logic g2, input logic [1:0] s,
                                   input logic x, input logic r, input logic [1:0] m);
    return {g1, g2, s, x, r, m};
  endfunction
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got g1g2_sel_xd_er_mask=%b expected %b", tag, obs, exp);
    end
  endtask
  task automatic compare_next();
    exp_t x;
    x = sb.pop_front();
    check(x.tag, {grant_1, grant_2, slave_sel, xfer_done, error, split_mask}, x.exp);
  endtask
  task automatic cyc(input string tag, input logic [7:0] exp);
    sb.push_back('{tag, exp});
    @(posedge clk);
    #1;
    compare_next();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    busreq_1 = 1'b0; busreq_2 = 1'b0; addr_valid = 1'b0; rdy = 1'b0;
    resp = 2'b00; addr = 16'h0; split_release_1 = 1'b0; split_release_2 = 1'b0;
    es = 2'd0; em = 2'b00;
    sb.push_back('{"reset", 8'h00});
    #1;
    compare_next();
    rst = 1'b0;
  endtask
  task automatic xfer(input string tag, input logic m2, input logic [15:0] a, input int waits, input logic [1:0] r);
    cyc({tag, "/grant"}, e(~m2, m2, es, 1'b0, 1'b0, em));
    addr_valid = 1'b1;
    addr = a;
    if (a[15:14] == 2'b11) begin
      cyc({tag, "/decode"}, e(1'b0, 1'b0, es, 1'b0, 1'b1, em));
      addr_valid = 1'b0;
      return;
    end
    es = a[15:14];
    cyc({tag, "/addr"}, e(~m2, m2, es, 1'b0, 1'b0, em));
    addr_valid = 1'b0;
    for (int i = 0; i < waits; i++) begin
      resp = 2'($urandom_range(3));
      cyc({tag, "/wait"}, e(~m2, m2, es, 1'b0, 1'b0, em));
    end
    rdy = 1'b1;
    resp = r;
`ifdef ARB_SPLIT_EN
    if (r == 2'b10) em[m2] = 1'b1;
`endif
    cyc({tag, "/resp"}, e(1'b0, 1'b0, es, r == 2'b00, r == 2'b01, em));
    rdy = 1'b0;
    resp = 2'b00;
  endtask
  initial begin
    rst = 1'b1;
    do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{"reset_clocked", 8'h00});
    compare_next();
    rst = 1'b0;
    // single OKAY transfer to slave 1 with one wait cycle
    busreq_1 = 1'b1;
    xfer("basic", 1'b0, 16'h4010, 1, 2'b00);
    busreq_1 = 1'b0;
    cyc("basic/idle", e(1'b0, 1'b0, es, 1'b0, 1'b0, em));
    // round-robin alternation
    do_reset();
    busreq_1 = 1'b1; busreq_2 = 1'b1;
    xfer("rr1", 1'b0, 16'h0000, 0, 2'b00);
    xfer("rr2", 1'b1, 16'h4abc, 1, 2'b00);
    xfer("rr3", 1'b0, 16'h8000, 2, 2'b00);
    xfer("rr4", 1'b1, 16'h1234, 0, 2'b00);
    busreq_1 = 1'b0; busreq_2 = 1'b0;
    cyc("rr/idle", e(1'b0, 1'b0, es, 1'b0, 1'b0, em));
    // split on master 2 (release held in the same cycle: set wins)
    do_reset();
    busreq_2 = 1'b1;
    split_release_2 = 1'b1;
    xfer("split", 1'b1, 16'h8000, 1, 2'b10);
    split_release_2 = 1'b0;
    busreq_1 = 1'b1;
    xfer("after_split", 1'b0, 16'h0010, 0, 2'b00);
    busreq_1 = 1'b0;
`ifdef ARB_SPLIT_EN
    cyc("masked", e(1'b0, 1'b0, es, 1'b0, 1'b0, 2'b10));
    split_release_2 = 1'b1;
    em = 2'b00;
    cyc("release", e(1'b0, 1'b0, es, 1'b0, 1'b0, em));
    split_release_2 = 1'b0;
`endif
    xfer("retry", 1'b1, 16'h4000, 0, 2'b11);
    xfer("resp_err", 1'b1, 16'h0100, 2, 2'b01);
    busreq_2 = 1'b0;
    cyc("err/idle", e(1'b0, 1'b0, es, 1'b0, 1'b0, em));
    // bad decode keeps previous slave_sel
    do_reset();
    busreq_1 = 1'b1;
    xfer("pre_bad", 1'b0, 16'h8000, 0, 2'b00);
    xfer("bad", 1'b0, 16'hC000, 0, 2'b00);
    busreq_1 = 1'b0;
    cyc("bad/idle", e(1'b0, 1'b0, es, 1'b0, 1'b0, em));
    // timeout after 15 wait cycles
    do_reset();
    busreq_2 = 1'b1;
    cyc("to/grant", e(1'b0, 1'b1, es, 1'b0, 1'b0, em));
    addr_valid = 1'b1;
    addr = 16'h4000;
    es = 2'd1;
    cyc("to/addr", e(1'b0, 1'b1, es, 1'b0, 1'b0, em));
    addr_valid = 1'b0;
    for (int i = 0; i < 15; i++) cyc("to/wait", e(1'b0, 1'b1, es, 1'b0, 1'b0, em));
    busreq_2 = 1'b0;
    cyc("to/fire", e(1'b0, 1'b0, es, 1'b0, 1'b1, em));
    cyc("to/after", e(1'b0, 1'b0, es, 1'b0, 1'b0, em));
    // asynchronous reset in the middle of a master-2 transfer
    do_reset();
    busreq_1 = 1'b1;
    xfer("pre_async", 1'b0, 16'h8000, 0, 2'b10);
    busreq_1 = 1'b0;
    busreq_2 = 1'b1;
    cyc("async/grant", e(1'b0, 1'b1, es, 1'b0, 1'b0, em));
    addr_valid = 1'b1;
    addr = 16'h4000;
    es = 2'd1;
    cyc("async/addr", e(1'b0, 1'b1, es, 1'b0, 1'b0, em));
    addr_valid = 1'b0;
    #2;
    do_reset();
    cyc("async/after", e(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
